// File: rtl/matrix_inversor_2x2_q.sv
// 2x2 signed fixed-point matrix inverter: adjugate divided by the determinant
// through one shared restoring divider, with saturation and singular detection.
`timescale 1ns/1ps
module matrix_inversor_2x2_q #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       startInv,
    input  logic [0:1][0:1][WIDTH-1:0] A,
    output logic [0:1][0:1][WIDTH-1:0] Res,
    output logic                       busy,
    output logic                       endInv,
    output logic                       singular,
    output logic                       overflow
);
    localparam int Q  = WIDTH + 2 * FRAC;
    localparam int DW = 2 * WIDTH + 1;
    localparam int CW = $clog2(Q);
    localparam logic [CW-1:0] LAST    = CW'(Q - 1);
    localparam logic [Q-1:0]  POS_MAX = {{(Q - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [Q-1:0]  NEG_LIM = POS_MAX + 1'b1;

    typedef enum logic [1:0] {IDLE, DET, DIV, DONE} state_t;
    state_t state_q, state_d;

    logic [0:1][0:1][WIDTH-1:0] a_q, res_q;
    logic [0:3][WIDTH:0]        adj_q, adj_c;
    logic [DW-1:0]              dmag_q, dmag_c;
    logic                       dneg_q, sing_q, ovf_q;
    logic [DW-1:0]              rem_q;
    logic [Q-2:0]               quo_q;
    logic [CW-1:0]              cnt_q;
    logic [1:0]                 elem_q;

    // Determinant and adjugate from the latched operands
    logic signed [2*WIDTH-1:0] p0, p1;
    logic signed [DW-1:0]      det_c;
    logic signed [WIDTH:0]     e00, e01, e10, e11;

    always_comb begin
        p0    = (2*WIDTH)'($signed(a_q[0][0])) * (2*WIDTH)'($signed(a_q[1][1]));
        p1    = (2*WIDTH)'($signed(a_q[0][1])) * (2*WIDTH)'($signed(a_q[1][0]));
        det_c = DW'(p0) - DW'(p1);
        dmag_c = det_c[DW-1] ? -det_c : det_c;
        e00 = (WIDTH+1)'($signed(a_q[0][0]));
        e01 = (WIDTH+1)'($signed(a_q[0][1]));
        e10 = (WIDTH+1)'($signed(a_q[1][0]));
        e11 = (WIDTH+1)'($signed(a_q[1][1]));
        adj_c[0] = e11;
        adj_c[1] = -e01;
        adj_c[2] = -e10;
        adj_c[3] = e00;
    end

    // One restoring-division step on magnitudes; sign and clamp on the last bit
    logic signed [WIDTH:0] adj_sel;
    logic [WIDTH-1:0]      amag, rval;
    logic [Q-1:0]          dvd, quo_nxt;
    logic [Q-2:0]          quo_cur;
    logic [CW-1:0]         idx;
    logic [DW-1:0]         rem_cur, rem_nxt;
    logic [DW:0]           trial;
    logic                  qbit, neg, sat;

    always_comb begin
        adj_sel = $signed(adj_q[elem_q]);
        amag    = adj_sel[WIDTH] ? WIDTH'(-adj_sel) : WIDTH'(adj_sel);
        dvd     = Q'(amag) << (2 * FRAC);
        idx     = LAST - cnt_q;
        rem_cur = (cnt_q == '0) ? '0 : rem_q;
        quo_cur = (cnt_q == '0) ? '0 : quo_q;
        trial   = {rem_cur, dvd[idx]} - {1'b0, dmag_q};
        qbit    = ~trial[DW];
        rem_nxt = qbit ? trial[DW-1:0] : {rem_cur[DW-2:0], dvd[idx]};
        quo_nxt = {quo_cur, qbit};
        neg     = adj_sel[WIDTH] ^ dneg_q;
        sat     = 1'b0;
        rval    = '0;
        if (!neg) begin
            if (quo_nxt > POS_MAX) begin
                sat  = 1'b1;
                rval = POS_MAX[WIDTH-1:0];
            end else begin
                rval = quo_nxt[WIDTH-1:0];
            end
        end else if (quo_nxt > NEG_LIM) begin
            sat  = 1'b1;
            rval = NEG_LIM[WIDTH-1:0];
        end else begin
            rval = -quo_nxt[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (startInv) state_d = DET;
            DET:  state_d = (det_c == '0) ? DONE : DIV;
            DIV:  if (elem_q == 2'd3 && cnt_q == LAST) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            res_q  <= '0;
            adj_q  <= '0;
            dmag_q <= '0;
            dneg_q <= 1'b0;
            sing_q <= 1'b0;
            ovf_q  <= 1'b0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            elem_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (startInv) begin
                    a_q    <= A;
                    res_q  <= '0;
                    sing_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end
                DET: begin
                    adj_q  <= adj_c;
                    dmag_q <= dmag_c;
                    dneg_q <= det_c[DW-1];
                    sing_q <= (det_c == '0);
                    rem_q  <= '0;
                    quo_q  <= '0;
                    cnt_q  <= '0;
                    elem_q <= '0;
                end
                DIV: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt[Q-2:0];
                    if (cnt_q == LAST) begin
                        cnt_q  <= '0;
                        elem_q <= elem_q + 2'd1;
                        res_q[elem_q[1]][elem_q[0]] <= rval;
                        if (sat) ovf_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Res      = res_q;
    assign busy     = (state_q != IDLE);
    assign endInv   = (state_q == DONE);
    assign singular = sing_q;
    assign overflow = ovf_q;
endmodule

// File: doc/matrix_inversor_2x2_q.md
# matrix_inversor_2x2_q

Sequential 2x2 signed fixed-point matrix inverter for the Kalman update path. It computes the inverse of the innovation covariance (S⁻¹) consumed by the gain stage. It extends the earlier unsigned integer 2x2 inversor with:
- a configurable Q format (WIDTH, FRAC);
- signed operands;
- a single shared iterative divider;
- singular-matrix detection, output saturation with an overflow flag, and a busy/done handshake.

## Interface
- WIDTH, 16, total bits per signed two's-complement element.
- FRAC, 8, fractional bits per element (0 ≤ FRAC < WIDTH); FRAC=0 gives integer mode.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- startInv  input  1  start request, sampled in IDLE.
- A  input  WIDTH×[0:1][0:1]  matrix to invert, sampled on the accepted start edge.
- Res  output  WIDTH×[0:1][0:1]  inverse in the same Q format, held until the next accepted start.
- busy  output  1  high from the accepted start through the DONE cycle.
- endInv  output  1  one-cycle completion pulse.
- singular  output  1  determinant was zero; valid with endInv and held.
- overflow  output  1  at least one element saturated; valid with endInv and held.

## Operation
- States and transitions:
  - IDLE: on startInv=1, go to DET.
  - DET: go to DONE if det=0, else go to DIV.
  - DIV: go to DONE after 4 element divisions.
  - DONE: go to IDLE.
- Accepted start:
  - A is latched into internal registers; later changes on A are ignored.
  - Res, singular and overflow are cleared.
- DET (1 cycle):
  - det = A00·A11 − A01·A10, full precision, 2·WIDTH+1 bits signed with 2·FRAC fractional bits.
  - The adjugate is formed: adj = [[A11, −A01], [−A10, A00]], each WIDTH+1 bits signed.
- DIV, element order 00, 01, 10, 11. For each element:
  - Res_ij = trunc_toward_zero(adj_ij · 2^(2·FRAC) / det).
  - Magnitudes are divided by a restoring divider of Q = WIDTH+2·FRAC iterations, one quotient bit per cycle.
  - The sign of the result is sign(adj_ij) XOR sign(det), applied after division.
- Saturation:
  - A positive quotient above 2^(WIDTH−1)−1 is clamped to 2^(WIDTH−1)−1.
  - A negative magnitude above 2^(WIDTH−1) is clamped to −2^(WIDTH−1).
  - Any clamp sets overflow.
- Singular (det=0):
  - No division is performed.
  - All Res = 0 and singular = 1.
- startInv handling:
  - Ignored while busy.
  - If it is still high in IDLE after DONE, a new operation is accepted on that edge (start is level-sensitive in IDLE).
- Reset (rst_n=0 on any edge, including mid-operation):
  - State goes to IDLE.
  - Res = 0, busy = 0, endInv = 0, singular = 0, overflow = 0.
  - The divider registers are cleared and the partial result is discarded.

## Timing
- Call the edge at which startInv is accepted edge 0.
- busy = 1 from edge 0.
- Non-singular operation:
  - DET occupies cycle 1.
  - DIV occupies cycles 2 … 1+4Q.
  - endInv = 1 in cycle 2+4Q.
  - WIDTH=16, FRAC=8 gives Q=32, so endInv is high in cycle 130.
  - Each Res_ij register updates on the edge that completes its last iteration.
  - Res is not guaranteed coherent until endInv.
- Singular operation: endInv = 1 in cycle 2.
- busy falls on the edge after the endInv cycle.
- The earliest next accepted start is that same edge, so there is one DONE/IDLE cycle between operations.
- Res, singular and overflow are stable from the endInv cycle until the next accepted start.

## Test plan
Defaults (WIDTH=16, FRAC=8) unless stated; values are raw integers.
- Kalman sample: A = [[2048, 5888], [512, 1536]] (8, 23, 2, 6) → det raw = 131072; Res = [[768, −2944], [−256, 1024]]; singular = 0, overflow = 0; endInv exactly at cycle 130.
- Integer mode, FRAC=0: A = [[8, 23], [2, 6]] → Res = [[3, −11], [−1, 4]] (−11.5 truncated toward zero); endInv at cycle 2+4·16 = 66.
- Negative determinant: A = [[0, 256], [256, 0]] → Res = [[0, 256], [256, 0]]. Identity: A = [[256, 0], [0, 256]] → identity.
- Singular and saturation:
  - A = [[256, 512], [512, 1024]] → singular = 1, Res all 0, endInv at cycle 2.
  - A = [[1, 0], [0, 1]] → Res = [[32767, 0], [0, 32767]], overflow = 1.
- Handshake:
  - startInv held high 5 cycles → exactly one operation, with a restart only if still high after DONE.
  - A changed during busy → result unaffected.
  - startInv pulsed while busy → ignored.
- Reset mid-DIV at cycle 40: rst_n low for one edge → all outputs 0, no endInv. A fresh start afterwards produces the correct Kalman-sample result at cycle 130.
